// File: rtl/temp_bcd_converter.sv
// temp_bcd_converter: turns an 8-bit degrees-C reading into three BCD digits,
// optionally converting to degrees F first (9c/5 + 32, truncating).
// Recomputes on input/unit change and on a periodic refresh.
module temp_bcd_converter #(
  parameter int unsigned REFRESH_CYCLES = 20000
) (
  input  logic       clk_200kHz,
  input  logic       reset_n,
  input  logic [7:0] temp_data,
  input  logic       unit_f,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [8:0] bin_value,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned CNT_W  = $clog2(REFRESH_CYCLES);
  localparam int unsigned DIV_W  = 12;
  localparam int unsigned BIN_W  = 9;
  localparam int unsigned SR_W   = 21;
  localparam int unsigned STEP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_ADD32,
    S_CONV,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [7:0]          last_temp_q;
  logic                last_unit_q;
  logic                pending_q;
  logic [CNT_W-1:0]    refresh_q;
  logic [STEP_W-1:0]   step_q;
  logic [DIV_W-1:0]    div_q;
  logic [2:0]          rem_q;
  logic [SR_W-1:0]     sr_q;
  logic [BIN_W-1:0]    bin_q;

  logic                trigger;
  logic                capture;
  logic [3:0]          div_trial;
  logic                div_bit;
  logic [2:0]          rem_d;
  logic [BIN_W-1:0]    add32;
  logic [SR_W-1:0]     sr_adj;

  // Trigger/capture decode, one restoring-divide step and the dabble adjust
  always_comb begin
    trigger = (temp_data != last_temp_q) || (unit_f != last_unit_q) ||
              (refresh_q == CNT_W'(REFRESH_CYCLES - 1));
    capture = (state_q == S_IDLE) && (pending_q || trigger);

    div_trial = {rem_q, div_q[DIV_W-1]};
    div_bit   = 1'b0;
    rem_d     = div_trial[2:0];
    if (div_trial >= 4'd5) begin
      div_bit = 1'b1;
      rem_d   = 3'(div_trial - 4'd5);
    end

    // Quotient is at most 459, so the 9-bit slice of the 12-bit result is exact
    add32 = 9'(div_q) + 9'd32;

    sr_adj = sr_q;
    if (sr_q[12:9] >= 4'd5)  sr_adj[12:9]  = sr_q[12:9]  + 4'd3;
    if (sr_q[16:13] >= 4'd5) sr_adj[16:13] = sr_q[16:13] + 4'd3;
    if (sr_q[20:17] >= 4'd5) sr_adj[20:17] = sr_q[20:17] + 4'd3;
  end

  // Change detection, pending flag and refresh counter
  always_ff @(posedge clk_200kHz or negedge reset_n) begin
    if (!reset_n) begin
      last_temp_q <= '0;
      last_unit_q <= 1'b0;
      pending_q   <= 1'b1;
      refresh_q   <= '0;
    end else if (capture) begin
      last_temp_q <= temp_data;
      last_unit_q <= unit_f;
      pending_q   <= 1'b0;
      refresh_q   <= '0;
    end else begin
      refresh_q <= refresh_q + CNT_W'(1);
      if (trigger) pending_q <= 1'b1;
    end
  end

  // Conversion FSM: optional divide-by-5 and +32, then serial double-dabble
  always_ff @(posedge clk_200kHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      sr_q      <= '0;
      bin_q     <= '0;
      bcd_hund  <= '0;
      bcd_tens  <= '0;
      bcd_ones  <= '0;
      bin_value <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (capture) begin
            step_q <= '0;
            rem_q  <= '0;
            busy   <= 1'b1;
            if (unit_f) begin
              div_q   <= DIV_W'({temp_data, 3'b000}) + DIV_W'(temp_data);
              state_q <= S_DIV;
            end else begin
              bin_q   <= {1'b0, temp_data};
              sr_q    <= {12'b0, 1'b0, temp_data};
              state_q <= S_CONV;
            end
          end
        end
        S_DIV: begin
          div_q  <= {div_q[DIV_W-2:0], div_bit};
          rem_q  <= rem_d;
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(DIV_W - 1)) state_q <= S_ADD32;
        end
        S_ADD32: begin
          bin_q   <= add32;
          sr_q    <= {12'b0, add32};
          step_q  <= '0;
          state_q <= S_CONV;
        end
        S_CONV: begin
          sr_q   <= SR_W'({sr_adj, 1'b0});
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(BIN_W - 1)) state_q <= S_DONE;
        end
        S_DONE: begin
          bcd_hund  <= sr_q[20:17];
          bcd_tens  <= sr_q[16:13];
          bcd_ones  <= sr_q[12:9];
          bin_value <= bin_q;
          valid     <= 1'b1;
          busy      <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
